jtag_dr_bank: RTL and testbench
===============================

// Module: jtag_dr_bank
// PURPOSE
// - Parametrised JTAG data-register bank behind the TAP controller/IR decoder.
// - Holds BYPASS, IDCODE, ADDR, DATA_WR, DATA_RD and a new CTRL_STATUS register.
// - Adds an AXI-side read-return path with valid/overrun tracking and a one-shot transaction-start strobe.
// - Sits between the TAP FSM and the JTAG-to-AXI master.
// PARAMETERS
// - IDCODE_VAL   32'h10F  value loaded into IDCODE at CAPTURE_DR
// - ADDR_WIDTH   32       ADDR register / addr_o width (8..64)
// - DATA_WIDTH   32       DATA_WR/DATA_RD payload width (8..64)
// - STATUS_WIDTH 4        external status bits reported in CTRL_STATUS (1..8)
// PORTS
// - tck          in   1             TAP clock
// - trstn        in   1             TAP reset
// - tdi          in   1             serial data in
// - tdo          out  1             serial data out
// - tap_state    in   tap_ctrl_fsm_t  current TAP state
// - ir_dec       in   ir_decoding_t   decoded instruction
// - rd_data_i    in   DATA_WIDTH    read data returned by AXI master
// - rd_valid_i   in   1             1-cycle strobe: rd_data_i valid (already in tck domain)
// - status_i     in   STATUS_WIDTH  AXI master status (busy, resp code, ...)
// - addr_o       out  ADDR_WIDTH    transaction address
// - wdata_o      out  DATA_WIDTH    write data
// - txn_start_o  out  1             1-cycle transaction-start pulse
// - txn_write_o  out  1             1=write, 0=read
// - txn_size_o   out  2             AXI size code (0=byte..3=dword)
// BEHAVIOUR
// - Clock and reset: single clock tck; reset trstn is asynchronous, active-low.
// - Reset values: all outputs 0, rd_valid/overrun 0, shift register 0.
// - TEST_LOGIC_RESET state acts as a synchronous reset of all state except IDCODE_VAL.
// - Shift register: SR_W = max(32, ADDR_WIDTH, DATA_WIDTH+1); active length L set by ir_dec:
//   - BYPASS = 1
//   - IDCODE = 32
//   - ADDR = ADDR_WIDTH
//   - DATA_WR = DATA_WIDTH
//   - DATA_RD = DATA_WIDTH+1
//   - CTRL_STATUS = 8
// - CAPTURE_DR (rising edge) loads the selected register into sr[L-1:0]. Capture sources:
//   - BYPASS: 0
//   - IDCODE: IDCODE_VAL
//   - ADDR: addr_o
//   - DATA_WR: wdata_o
//   - DATA_RD: {rd_data_q, rd_valid}
//   - CTRL_STATUS: {status_i (zero-ext/trunc to 6 bits), overrun, rd_valid}
// - SHIFT_DR (rising edge): sr <= {tdi into bit L-1, sr[L-1:1]}; bits >= L hold.
// - tdo is registered on the falling edge of tck:
//   - equals sr[0] while tap_state==SHIFT_DR;
//   - otherwise 0.
//   - Any unlisted ir_dec gives tdo=0 and no state change.
// - UPDATE_DR (rising edge at end of state):
//   - ADDR: addr_o <= sr[ADDR_WIDTH-1:0].
//   - DATA_WR: wdata_o <= sr[DATA_WIDTH-1:0].
//   - DATA_RD: rd_valid <= 0 (read-clear). Payload is not writable.
//   - CTRL_STATUS bits:
//     - sr[0] start: txn_start_o high for exactly the next tck cycle.
//     - sr[1] -> txn_write_o.
//     - sr[2] = 1 clears overrun.
//     - sr[4:3] -> txn_size_o.
//     - sr[7:5] reserved/ignored.
//   - Start with write=0 also clears rd_valid, so the next read is fresh.
// - Read return: on rd_valid_i, rd_data_q <= rd_data_i and rd_valid <= 1.
//   - If rd_valid is already 1: data is overwritten and overrun <= 1 (sticky).
// - Simultaneous events:
//   - rd_valid_i in the same cycle as a DATA_RD UPDATE_DR clear: the new data wins (rd_valid=1, no overrun).
//   - rd_valid_i with overrun-clear in the same cycle: overrun is set only if the overwrite condition holds.
// - Latency: addr_o/wdata_o/txn_* change on the rising edge that leaves UPDATE_DR; no combinational path from tdi to any output.
// - trstn mid-shift: everything returns to reset values immediately; txn_start_o drops asynchronously.
// STRUCTURE
// - jtag_pkg: extend ir_decoding_t with CTRL_STATUS. Add:
//   - ctrl_bits_t packed struct {rsvd[2:0], size[1:0], clr_ovr, write, start};
//   - localparam CTRL_SR_LEN=8 and AXI size codes.
// - Sub-module jtag_dr_shifter #(SR_W):
//   - variable-length capture/shift register;
//   - inputs capture_en, shift_en, len, cap_val, tdi;
//   - outputs sr, tdo (negedge flop).
// - The bank holds update registers, read-return logic and the strobe.
// TESTING
// - Reset: pulse trstn low mid-SHIFT_DR -> all outputs 0, tdo 0, next IDCODE capture shifts out 0x0000010F LSB first.
// - ADDR: shift 0xDEADBEEF, pass UPDATE_DR -> addr_o=0xDEADBEEF; re-capture and shift 32 zeros -> tdo returns 0xDEADBEEF.
// - Read return: rd_valid_i with rd_data_i=0xCAFE0001, then DATA_RD capture/shift 33 bits -> bit0=1, bits[32:1]=0xCAFE0001; after UPDATE_DR, recapture -> bit0=0.
// - Overrun: two rd_valid_i (0x11, then 0x22) without reading -> CTRL_STATUS bit1=1, data=0x22; CTRL write 0x04 -> bit1=0.
// - CTRL write 0x1B (start, write, size=3) -> txn_start_o high exactly 1 cycle, txn_write_o=1, txn_size_o=3.
// - Collision: rd_valid_i on the DATA_RD UPDATE_DR edge -> rd_valid stays 1, overrun 0. BYPASS shift 1,0,1 -> tdo 0,1,0 delayed one bit.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP state, instruction decode and CTRL_STATUS field definitions for the
// JTAG data-register bank.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_ctrl_fsm_t;

    typedef enum logic [2:0] {
        IR_BYPASS      = 3'd0,
        IR_IDCODE      = 3'd1,
        IR_ADDR        = 3'd2,
        IR_DATA_WR     = 3'd3,
        IR_DATA_RD     = 3'd4,
        IR_CTRL_STATUS = 3'd5
    } ir_decoding_t;

    typedef enum logic [1:0] {
        AXI_SIZE_BYTE  = 2'd0,
        AXI_SIZE_HALF  = 2'd1,
        AXI_SIZE_WORD  = 2'd2,
        AXI_SIZE_DWORD = 2'd3
    } axi_size_t;

    typedef struct packed {
        logic [2:0] rsvd;
        logic [1:0] size;
        logic       clr_ovr;
        logic       write;
        logic       start;
    } ctrl_bits_t;

    localparam int CTRL_SR_LEN = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// Variable-length capture/shift register; tdo is launched on the falling edge of tck.
module jtag_dr_shifter #(
    parameter int SR_W  = 33,
    parameter int LEN_W = $clog2(SR_W + 1)
) (
    input  logic             tck,
    input  logic             trstn,
    input  logic             sync_clr,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic             tdo_en,
    input  logic [LEN_W-1:0] len,
    input  logic [SR_W-1:0]  cap_val,
    input  logic             tdi,
    output logic [SR_W-1:0]  sr,
    output logic             tdo
);

    logic [SR_W-1:0] sr_q, sr_d, sr_shr;
    logic            tdo_q, tdo_d;

    assign sr_shr = sr_q >> 1;

    always_comb begin
        sr_d = sr_q;
        if (sync_clr) begin
            sr_d = '0;
        end else if (capture_en) begin
            for (int i = 0; i < SR_W; i++) begin
                if (i < int'(len)) sr_d[i] = cap_val[i];
            end
        end else if (shift_en) begin
            // Only the active window [len-1:0] moves; bits above it hold.
            for (int i = 0; i < SR_W; i++) begin
                if (i == int'(len) - 1)     sr_d[i] = tdi;
                else if (i < int'(len) - 1) sr_d[i] = sr_shr[i];
            end
        end
    end

    always_comb begin
        tdo_d = tdo_en ? sr_q[0] : 1'b0;
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) tdo_q <= 1'b0;
        else        tdo_q <= tdo_d;
    end

    assign sr  = sr_q;
    assign tdo = tdo_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: capture sources, UPDATE_DR side effects, AXI read-return
// tracking (valid/overrun) and the one-shot transaction-start strobe.
module jtag_dr_bank
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL   = 32'h10F,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          STATUS_WIDTH = 4
) (
    input  logic                    tck,
    input  logic                    trstn,
    input  logic                    tdi,
    output logic                    tdo,
    input  tap_ctrl_fsm_t           tap_state,
    input  ir_decoding_t            ir_dec,
    input  logic [DATA_WIDTH-1:0]   rd_data_i,
    input  logic                    rd_valid_i,
    input  logic [STATUS_WIDTH-1:0] status_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic                    txn_start_o,
    output logic                    txn_write_o,
    output logic [1:0]              txn_size_o
);

    localparam int SR_W  = max3(32, ADDR_WIDTH, DATA_WIDTH + 1);
    localparam int LEN_W = $clog2(SR_W + 1);
    localparam int ST_N  = (STATUS_WIDTH < 6) ? STATUS_WIDTH : 6;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  start_q, start_d;
    logic                  write_q, write_d;
    axi_size_t             size_q, size_d;

    logic                  ir_known, tlr, upd_en, rd_clr;
    logic [LEN_W-1:0]      len;
    logic [SR_W-1:0]       cap_val, sr;
    logic [5:0]            status6;
    ctrl_bits_t            ctrl_w;
    logic                  unused_bits;

    assign status6     = 6'(status_i[ST_N-1:0]);
    assign ctrl_w      = ctrl_bits_t'(sr[CTRL_SR_LEN-1:0]);
    assign tlr         = (tap_state == TEST_LOGIC_RESET);
    assign upd_en      = (tap_state == UPDATE_DR) && ir_known;
    // Reserved CTRL bits and shift bits beyond every update window carry no meaning.
    assign unused_bits = ^{sr, ctrl_w.rsvd};

    always_comb begin
        ir_known = 1'b1;
        len      = LEN_W'(1);
        cap_val  = '0;
        case (ir_dec)
            IR_BYPASS:      len = LEN_W'(1);
            IR_IDCODE: begin
                len     = LEN_W'(32);
                cap_val = SR_W'(IDCODE_VAL);
            end
            IR_ADDR: begin
                len     = LEN_W'(ADDR_WIDTH);
                cap_val = SR_W'(addr_q);
            end
            IR_DATA_WR: begin
                len     = LEN_W'(DATA_WIDTH);
                cap_val = SR_W'(wdata_q);
            end
            IR_DATA_RD: begin
                len     = LEN_W'(DATA_WIDTH + 1);
                cap_val = SR_W'({rd_data_q, rd_valid_q});
            end
            IR_CTRL_STATUS: begin
                len     = LEN_W'(CTRL_SR_LEN);
                cap_val = SR_W'({status6, overrun_q, rd_valid_q});
            end
            default:        ir_known = 1'b0;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;
        start_d    = 1'b0;
        write_d    = write_q;
        size_d     = size_q;
        rd_clr     = 1'b0;
        if (tlr) begin
            addr_d     = '0;
            wdata_d    = '0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
            overrun_d  = 1'b0;
            write_d    = 1'b0;
            size_d     = AXI_SIZE_BYTE;
        end else begin
            if (upd_en) begin
                case (ir_dec)
                    IR_ADDR:    addr_d  = sr[ADDR_WIDTH-1:0];
                    IR_DATA_WR: wdata_d = sr[DATA_WIDTH-1:0];
                    IR_DATA_RD: rd_clr  = 1'b1;
                    IR_CTRL_STATUS: begin
                        start_d = ctrl_w.start;
                        write_d = ctrl_w.write;
                        size_d  = axi_size_t'(ctrl_w.size);
                        if (ctrl_w.clr_ovr) overrun_d = 1'b0;
                        // Launching a read discards any stale return so the next one is fresh.
                        if (ctrl_w.start && !ctrl_w.write) rd_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_clr) rd_valid_d = 1'b0;
            // A return landing on the clearing edge counts as fresh data, not an overwrite.
            if (rd_valid_i) begin
                rd_data_d  = rd_data_i;
                rd_valid_d = 1'b1;
                if (rd_valid_q && !rd_clr) overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            start_q    <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= AXI_SIZE_BYTE;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            start_q    <= start_d;
            write_q    <= write_d;
            size_q     <= size_d;
        end
    end

    jtag_dr_shifter #(
        .SR_W  (SR_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .tck        (tck),
        .trstn      (trstn),
        .sync_clr   (tlr),
        .capture_en ((tap_state == CAPTURE_DR) && ir_known),
        .shift_en   ((tap_state == SHIFT_DR) && ir_known),
        .tdo_en     ((tap_state == SHIFT_DR) && ir_known),
        .len        (len),
        .cap_val    (cap_val),
        .tdi        (tdi),
        .sr         (sr),
        .tdo        (tdo)
    );

    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign txn_start_o = start_q;
    assign txn_write_o = write_q;
    assign txn_size_o  = size_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Scoreboard bench for jtag_dr_bank: a driver walks the TAP through DR scans and
// pushes expected tdo bits / post-update outputs; a monitor pops and compares.
module tb_jtag_dr_bank;
    import jtag_pkg::*;

    logic          tck = 1'b0;
    logic          trstn;
    logic          tdi;
    logic          tdo;
    tap_ctrl_fsm_t tap_state;
    ir_decoding_t  ir_dec;
    logic [31:0]   rd_data_i;
    logic          rd_valid_i;
    logic [3:0]    status_i;
    logic [31:0]   addr_o;
    logic [31:0]   wdata_o;
    logic          txn_start_o;
    logic          txn_write_o;
    logic [1:0]    txn_size_o;

    jtag_dr_bank #(
        .IDCODE_VAL   (32'h10F),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STATUS_WIDTH (4)
    ) dut (
        .tck         (tck),
        .trstn       (trstn),
        .tdi         (tdi),
        .tdo         (tdo),
        .tap_state   (tap_state),
        .ir_dec      (ir_dec),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i),
        .status_i    (status_i),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .txn_start_o (txn_start_o),
        .txn_write_o (txn_write_o),
        .txn_size_o  (txn_size_o)
    );

    always #5 tck = ~tck;

    int n_vec = 0;
    int n_err = 0;

    bit          exp_tdo[$];
    logic [67:0] exp_out[$];

    // Reference model state
    logic [31:0] m_addr, m_wdata, m_rd_data;
    bit          m_rdv, m_ovr, m_wr;
    logic [1:0]  m_size;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_wdata = '0; m_rd_data = '0;
        m_rdv = 0; m_ovr = 0; m_wr = 0; m_size = '0;
    endtask

    function automatic logic [63:0] model_capture(input ir_decoding_t ir);
        case (ir)
            IR_IDCODE:      return 64'h10F;
            IR_ADDR:        return {32'h0, m_addr};
            IR_DATA_WR:     return {32'h0, m_wdata};
            IR_DATA_RD:     return {31'h0, m_rd_data, m_rdv};
            IR_CTRL_STATUS: return {56'h0, 2'b00, status_i, m_ovr, m_rdv};
            default:        return 64'h0;
        endcase
    endfunction

    function automatic int len_of(input ir_decoding_t ir);
        case (ir)
            IR_IDCODE, IR_ADDR, IR_DATA_WR: return 32;
            IR_DATA_RD:                     return 33;
            IR_CTRL_STATUS:                 return 8;
            default:                        return 1;
        endcase
    endfunction

    task automatic step();
        @(posedge tck);
        #2;
    endtask

    task automatic rd_return(input logic [31:0] d);
        rd_valid_i = 1'b1;
        rd_data_i  = d;
        if (m_rdv) m_ovr = 1;
        m_rd_data = d;
        m_rdv     = 1;
        step();
        rd_valid_i = 1'b0;
        step();
    endtask

    // One DR scan from RUN_TEST_IDLE: n bits of din shifted LSB first.
    task automatic scan(input ir_decoding_t ir, input logic [63:0] din, input int n,
                        input bit upd, input bit rd_at_upd, input logic [31:0] rd_dat);
        logic [63:0]  cap;
        logic [127:0] seq;
        logic [63:0]  nv;
        int           L;
        bit           known;
        bit           clr;
        bit           start;
        known    = (int'(ir) <= 5);
        ir_dec   = ir;
        status_i = 4'($urandom);
        tap_state = SELECT_DR;
        step();
        cap = model_capture(ir);
        L   = len_of(ir);
        // The register is a window of L bits on the stream {captured bits, tdi bits}.
        seq = '0;
        for (int i = 0; i < L; i++) seq[i] = cap[i];
        for (int i = 0; i < n; i++) seq[L+i] = din[i];
        for (int i = 0; i < n; i++) exp_tdo.push_back(known ? seq[i] : 1'b0);
        nv = '0;
        for (int j = 0; j < L; j++) nv[j] = seq[n+j];
        tap_state = CAPTURE_DR;
        step();
        for (int i = 0; i < n; i++) begin
            tap_state = SHIFT_DR;
            tdi = din[i];
            step();
        end
        if (!upd) return;
        tap_state = EXIT1_DR;
        step();
        tap_state = UPDATE_DR;
        clr   = 0;
        start = 0;
        if (known) begin
            case (ir)
                IR_ADDR:    m_addr  = nv[31:0];
                IR_DATA_WR: m_wdata = nv[31:0];
                IR_DATA_RD: clr = 1;
                IR_CTRL_STATUS: begin
                    start  = nv[0];
                    m_wr   = nv[1];
                    m_size = nv[4:3];
                    if (nv[2]) m_ovr = 0;
                    if (nv[0] && !nv[1]) clr = 1;
                end
                default: ;
            endcase
        end
        if (clr) m_rdv = 0;
        if (rd_at_upd) begin
            rd_valid_i = 1'b1;
            rd_data_i  = rd_dat;
            if (m_rdv) m_ovr = 1;
            m_rd_data = rd_dat;
            m_rdv     = 1;
        end
        exp_out.push_back({m_addr, m_wdata, m_wr, m_size, start});
        step();
        rd_valid_i = 1'b0;
        tap_state  = RUN_TEST_IDLE;
        step();
    endtask

    // Monitor: tdo is meaningful in SHIFT_DR; outputs settle on the edge leaving UPDATE_DR.
    initial begin
        forever begin
            @(posedge tck);
            #1;
            if (tap_state == SHIFT_DR) begin
                if (exp_tdo.size() == 0) check("tdo_unexpected_shift", 68'd1, 68'd0);
                else check("tdo_bit", 68'(tdo), 68'(exp_tdo.pop_front()));
            end
            if (tap_state == UPDATE_DR) begin
                if (exp_out.size() == 0) check("update_unexpected", 68'd1, 68'd0);
                else check("outputs_after_update",
                           {addr_o, wdata_o, txn_write_o, txn_size_o, txn_start_o},
                           exp_out.pop_front());
            end else begin
                check("txn_start_idle", 68'(txn_start_o), 68'd0);
            end
        end
    end

    initial begin
        trstn      = 1'b0;
        tdi        = 1'b0;
        tap_state  = TEST_LOGIC_RESET;
        ir_dec     = IR_BYPASS;
        rd_data_i  = '0;
        rd_valid_i = 1'b0;
        status_i   = '0;
        model_reset();
        #3;
        check("reset_outputs", {addr_o, wdata_o, txn_write_o, txn_size_o, txn_start_o}, 68'd0);
        check("reset_tdo", 68'(tdo), 68'd0);
        #1 trstn = 1'b1;
        step();
        tap_state = RUN_TEST_IDLE;
        step();

        scan(IR_IDCODE, 64'h0, 32, 1, 0, 0);
        scan(IR_ADDR, 64'hDEADBEEF, 32, 1, 0, 0);
        scan(IR_ADDR, 64'h0, 32, 1, 0, 0);

        rd_return(32'hCAFE0001);
        scan(IR_DATA_RD, 64'h0, 33, 1, 0, 0);
        scan(IR_DATA_RD, 64'h0, 33, 1, 0, 0);

        rd_return(32'h11);
        rd_return(32'h22);
        scan(IR_CTRL_STATUS, 64'h00, 8, 1, 0, 0);
        scan(IR_DATA_RD, 64'h0, 33, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h04, 8, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h00, 8, 1, 0, 0);

        scan(IR_CTRL_STATUS, 64'h1B, 8, 1, 0, 0);

        rd_return(32'h33);
        scan(IR_DATA_RD, 64'h0, 33, 1, 1, 32'h44);
        scan(IR_CTRL_STATUS, 64'h00, 8, 1, 0, 0);
        scan(IR_DATA_RD, 64'h0, 33, 1, 0, 0);

        scan(IR_BYPASS, 64'b101, 3, 1, 0, 0);
        scan(ir_decoding_t'(3'd6), 64'h3FF, 10, 1, 0, 0);

        // Trstn pulse mid-shift with non-zero outputs.
        scan(IR_ADDR, 64'h12345678, 32, 1, 0, 0);
        scan(IR_DATA_WR, 64'h9ABCDEF0, 32, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h1A, 8, 1, 0, 0);
        rd_return(32'h55);
        scan(IR_IDCODE, 64'h0, 5, 0, 0, 0);
        trstn     = 1'b0;
        tap_state = TEST_LOGIC_RESET;
        #1;
        check("trst_mid_shift_outputs", {addr_o, wdata_o, txn_write_o, txn_size_o, txn_start_o}, 68'd0);
        check("trst_mid_shift_tdo", 68'(tdo), 68'd0);
        model_reset();
        #1 trstn = 1'b1;
        step();
        tap_state = RUN_TEST_IDLE;
        step();
        scan(IR_IDCODE, 64'h0, 32, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h0, 8, 1, 0, 0);

        // TEST_LOGIC_RESET as synchronous clear.
        scan(IR_ADDR, 64'hA5A5A5A5, 32, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h1A, 8, 1, 0, 0);
        rd_return(32'h66);
        rd_return(32'h77);
        tap_state = TEST_LOGIC_RESET;
        step();
        model_reset();
        tap_state = RUN_TEST_IDLE;
        step();
        scan(ir_decoding_t'(3'd7), 64'h5, 4, 1, 0, 0);
        scan(IR_CTRL_STATUS, 64'h0, 8, 1, 0, 0);
        scan(IR_DATA_RD, 64'h0, 33, 1, 0, 0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 6))
                0: scan(IR_ADDR, {$urandom, $urandom}, 32, 1, 0, 0);
                1: scan(IR_DATA_WR, {$urandom, $urandom}, 32, 1, 0, 0);
                2: rd_return($urandom);
                3: scan(IR_DATA_RD, {$urandom, $urandom}, 33, 1, 1'($urandom_range(0, 1)), $urandom);
                4: scan(IR_CTRL_STATUS, 64'($urandom_range(0, 255)), 8, 1, 0, 0);
                5: scan(IR_IDCODE, 64'h0, 32, 1, 0, 0);
                default: scan(IR_BYPASS, {$urandom, $urandom}, $urandom_range(1, 6), 1, 0, 0);
            endcase
        end

        step();
        step();
        check("tdo_queue_drained", 68'(exp_tdo.size()), 68'd0);
        check("out_queue_drained", 68'(exp_out.size()), 68'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
